// File: rtl/mem_access_unit.sv
// Memory-stage access controller: issues dcache requests, stalls until dhit,
// registers load/sc results for MEM/WB and maintains the LL/SC link register.
module mem_access_unit #(
    parameter bit LLSC_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        valid_in,
    input  logic        memread_in,
    input  logic        memwrite_in,
    input  logic        ll_in,
    input  logic        sc_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] storedata_in,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    input  logic        snoop_inv,
    input  logic [31:0] snoop_addr,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic [31:0] dMemLoad,
    output logic        sc_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, next_state;
    logic [29:0] addr_q;
    logic [31:0] data_q;
    logic        rd_q, wr_q, ll_q, sc_q;
    logic [31:0] load_q;
    logic        sc_res_q;
    logic        link_valid;
    logic [29:0] link_addr;

    logic memop, is_ll, is_sc, link_ok, sc_fail, capture, complete, snoop_hit;

    // Byte offsets never take part in word-granular matching.
    logic unused_byte_bits;
    assign unused_byte_bits = ^{addr_in[1:0], snoop_addr[1:0]};

    assign memop     = valid_in & (memread_in | memwrite_in);
    assign is_sc     = LLSC_EN & memwrite_in & sc_in;
    assign is_ll     = LLSC_EN & memread_in & ~memwrite_in & ll_in;
    assign link_ok   = link_valid && (link_addr == addr_in[31:2]) &&
                       !(snoop_inv && (snoop_addr[31:2] == addr_in[31:2]));
    assign sc_fail   = (state == IDLE) & memop & is_sc & ~link_ok;
    assign capture   = (state == IDLE) & memop & ~sc_fail;
    assign complete  = (state == BUSY) & dhit;
    assign snoop_hit = snoop_inv & (snoop_addr[31:2] == link_addr);

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        unique case (state)
            IDLE: if (sc_fail) next_state = DONE;
                  else if (memop) next_state = BUSY;
            BUSY: if (dhit) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            ll_q       <= 1'b0;
            sc_q       <= 1'b0;
            load_q     <= '0;
            sc_res_q   <= 1'b0;
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else begin
            state <= next_state;

            if (capture) begin
                addr_q <= addr_in[31:2];
                data_q <= storedata_in;
                wr_q   <= memwrite_in;
                rd_q   <= memread_in & ~memwrite_in;
                ll_q   <= is_ll;
                sc_q   <= is_sc;
            end

            if (complete && rd_q) load_q <= dmemload;
            if (complete && sc_q) begin
                load_q   <= 32'd1;
                sc_res_q <= 1'b1;
            end
            if (sc_fail) begin
                load_q   <= 32'd0;
                sc_res_q <= 1'b0;
            end

            // A completing ll outranks every clear: it observed data after any invalidation.
            if (complete && ll_q) begin
                link_valid <= 1'b1;
                link_addr  <= addr_q;
            end else if (sc_fail || (complete && sc_q) || snoop_hit ||
                         (complete && wr_q && (addr_q == link_addr))) begin
                link_valid <= 1'b0;
            end
        end
    end

    assign dREN      = (state == BUSY) & rd_q;
    assign dWEN      = (state == BUSY) & wr_q;
    assign dmemaddr  = {addr_q, 2'b00};
    assign dmemstore = data_q;
    assign mem_stall = ((state == IDLE) & memop) | (state == BUSY);
    assign dMemLoad  = load_q;
    assign sc_result = LLSC_EN ? sc_res_q : 1'b1;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: latency, data, LL/SC and reset.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        valid_in, memread_in, memwrite_in, ll_in, sc_in;
    logic [31:0] addr_in, storedata_in;
    logic        dhit;
    logic [31:0] dmemload;
    logic        snoop_inv;
    logic [31:0] snoop_addr;
    logic        dREN, dWEN, mem_stall, sc_result;
    logic [31:0] dmemaddr, dmemstore, dMemLoad;

    mem_access_unit dut (
        .CLK          (CLK),
        .RST          (RST),
        .valid_in     (valid_in),
        .memread_in   (memread_in),
        .memwrite_in  (memwrite_in),
        .ll_in        (ll_in),
        .sc_in        (sc_in),
        .addr_in      (addr_in),
        .storedata_in (storedata_in),
        .dhit         (dhit),
        .dmemload     (dmemload),
        .snoop_inv    (snoop_inv),
        .snoop_addr   (snoop_addr),
        .dREN         (dREN),
        .dWEN         (dWEN),
        .dmemaddr     (dmemaddr),
        .dmemstore    (dmemstore),
        .mem_stall    (mem_stall),
        .dMemLoad     (dMemLoad),
        .sc_result    (sc_result)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Per-operation observations.
    int          r_stall, r_ren, r_wen, r_first, r_done;
    int          r_both = 0;
    logic [31:0] r_addr, r_store, r_load;
    logic        r_scr;

    // Presents one instruction and holds it until the DONE cycle (first non-stall cycle).
    // dhit is raised on the n_busy-th cycle after the IDLE cycle.
    task automatic do_op(input logic rd, input logic wr, input logic ll, input logic sc,
                         input logic [31:0] addr, input logic [31:0] data, input int n_busy,
                         input logic [31:0] rdata, input logic snp, input logic [31:0] snp_a);
        int c;
        bit done;
        r_stall = 0; r_ren = 0; r_wen = 0; r_first = -1; done = 0;
        r_addr = '0; r_store = '0;
        @(posedge CLK); #1;
        valid_in = 1'b1; memread_in = rd; memwrite_in = wr; ll_in = ll; sc_in = sc;
        addr_in = addr; storedata_in = data; dmemload = rdata; dhit = 1'b0;
        snoop_inv = snp; snoop_addr = snp_a;
        c = 0;
        while (!done && c < 40) begin
            #1;
            if (mem_stall) r_stall++;
            if (dREN) r_ren++;
            if (dWEN) r_wen++;
            if (dREN && dWEN) r_both++;
            if (dREN || dWEN) begin
                r_addr = dmemaddr;
                r_store = dmemstore;
                if (r_first < 0) r_first = cyc;
            end
            if (!mem_stall && c > 0) begin
                done = 1;
                r_load = dMemLoad;
                r_scr = sc_result;
                r_done = cyc;
            end else begin
                @(posedge CLK); #1;
                c++;
                snoop_inv = 1'b0;
                dhit = (c == n_busy);
            end
        end
        if (!done) check("op_timeout", 32'd0, 32'd1);
    endtask

    task automatic snoop(input logic [31:0] a);
        @(posedge CLK); #1;
        valid_in = 1'b0; snoop_inv = 1'b1; snoop_addr = a;
        @(posedge CLK); #1;
        snoop_inv = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev_done;
        RST = 1'b1; valid_in = 0; memread_in = 0; memwrite_in = 0; ll_in = 0; sc_in = 0;
        addr_in = '0; storedata_in = '0; dhit = 0; dmemload = '0; snoop_inv = 0; snoop_addr = '0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        #1;
        check("rst_dren", 32'(dREN), 32'd0);
        check("rst_dwen", 32'(dWEN), 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_load", dMemLoad, 32'd0);
        check("rst_scr", 32'(sc_result), 32'd0);

        // lw 0x104, dhit on the third BUSY cycle
        do_op(1, 0, 0, 0, 32'h0000_0104, 32'h0, 3, 32'hDEAD_BEEF, 0, 32'h0);
        check("lw_stall", 32'(r_stall), 32'd4);
        check("lw_dren", 32'(r_ren), 32'd3);
        check("lw_dwen", 32'(r_wen), 32'd0);
        check("lw_addr", r_addr, 32'h0000_0104);
        check("lw_load", r_load, 32'hDEAD_BEEF);

        // sw 0x203, immediate dhit
        do_op(0, 1, 0, 0, 32'h0000_0203, 32'h1234_5678, 1, 32'h5555_5555, 0, 32'h0);
        check("sw_dwen", 32'(r_wen), 32'd1);
        check("sw_dren", 32'(r_ren), 32'd0);
        check("sw_addr", r_addr, 32'h0000_0200);
        check("sw_store", r_store, 32'h1234_5678);
        check("sw_stall", 32'(r_stall), 32'd2);
        check("sw_load_kept", r_load, 32'hDEAD_BEEF);

        // ll then sc with no intervening events
        do_op(1, 0, 1, 0, 32'h40, 32'h0, 1, 32'hA5A5_A5A5, 0, 32'h0);
        check("ll_load", r_load, 32'hA5A5_A5A5);
        do_op(0, 1, 0, 1, 32'h40, 32'h77, 1, 32'h0, 0, 32'h0);
        check("sc_ok_dwen", 32'(r_wen), 32'd1);
        check("sc_ok_store", r_store, 32'h77);
        check("sc_ok_scr", 32'(r_scr), 32'd1);
        check("sc_ok_load", r_load, 32'd1);
        check("sc_ok_stall", 32'(r_stall), 32'd2);
        // link consumed: a repeat sc fails
        do_op(0, 1, 0, 1, 32'h40, 32'h78, 1, 32'h0, 0, 32'h0);
        check("sc_again_dwen", 32'(r_wen), 32'd0);
        check("sc_again_scr", 32'(r_scr), 32'd0);

        // snoop to same word (different byte) kills the link
        do_op(1, 0, 1, 0, 32'h40, 32'h0, 1, 32'h1111_1111, 0, 32'h0);
        snoop(32'h42);
        do_op(0, 1, 0, 1, 32'h40, 32'h99, 1, 32'h0, 0, 32'h0);
        check("snp_dwen", 32'(r_wen), 32'd0);
        check("snp_scr", 32'(r_scr), 32'd0);
        check("snp_load", r_load, 32'd0);
        check("snp_stall", 32'(r_stall), 32'd1);

        // sw to the linked word kills the link
        do_op(1, 0, 1, 0, 32'h40, 32'h0, 1, 32'h2222_2222, 0, 32'h0);
        do_op(0, 1, 0, 0, 32'h40, 32'h5, 1, 32'h0, 0, 32'h0);
        do_op(0, 1, 0, 1, 32'h40, 32'h6, 1, 32'h0, 0, 32'h0);
        check("swk_dwen", 32'(r_wen), 32'd0);
        check("swk_scr", 32'(r_scr), 32'd0);
        check("swk_load", r_load, 32'd0);
        check("swk_stall", 32'(r_stall), 32'd1);

        // sw and snoop to other words keep the link
        do_op(1, 0, 1, 0, 32'h40, 32'h0, 1, 32'h3333_3333, 0, 32'h0);
        do_op(0, 1, 0, 0, 32'h80, 32'h5, 1, 32'h0, 0, 32'h0);
        snoop(32'h44);
        do_op(0, 1, 0, 1, 32'h40, 32'h6, 2, 32'h0, 0, 32'h0);
        check("keep_dwen", 32'(r_wen), 32'd2);
        check("keep_scr", 32'(r_scr), 32'd1);
        check("keep_stall", 32'(r_stall), 32'd3);

        // snoop in the same cycle as the sc link check
        do_op(1, 0, 1, 0, 32'h40, 32'h0, 1, 32'h4444_4444, 0, 32'h0);
        do_op(0, 1, 0, 1, 32'h40, 32'h6, 1, 32'h0, 1, 32'h40);
        check("snp_same_dwen", 32'(r_wen), 32'd0);
        check("snp_same_scr", 32'(r_scr), 32'd0);

        // bubble with memread asserted
        @(posedge CLK); #1;
        valid_in = 1'b0; memread_in = 1'b1; memwrite_in = 1'b0; ll_in = 0; sc_in = 0; addr_in = 32'h10;
        #1;
        check("bub_stall0", 32'(mem_stall), 32'd0);
        check("bub_dren0", 32'(dREN), 32'd0);
        @(posedge CLK); #1;
        check("bub_stall1", 32'(mem_stall), 32'd0);
        check("bub_dren1", 32'(dREN), 32'd0);

        // back-to-back loads
        do_op(1, 0, 0, 0, 32'h10, 32'h0, 1, 32'hAAAA_0001, 0, 32'h0);
        prev_done = r_done;
        do_op(1, 0, 0, 0, 32'h14, 32'h0, 1, 32'hAAAA_0002, 0, 32'h0);
        check("b2b_gap", 32'(r_first - prev_done), 32'd2);
        check("b2b_load", r_load, 32'hAAAA_0002);

        // reset mid-BUSY after sc_result=1 and a live link
        do_op(1, 0, 1, 0, 32'h40, 32'h0, 1, 32'h0, 0, 32'h0);
        do_op(0, 1, 0, 1, 32'h40, 32'h1, 1, 32'h0, 0, 32'h0);
        do_op(1, 0, 1, 0, 32'h80, 32'h0, 1, 32'hCAFE_F00D, 0, 32'h0);
        check("pre_rst_load", r_load, 32'hCAFE_F00D);
        check("pre_rst_scr", 32'(r_scr), 32'd1);
        @(posedge CLK); #1;
        valid_in = 1; memread_in = 1; memwrite_in = 0; ll_in = 0; sc_in = 0; addr_in = 32'h300; dhit = 0;
        @(posedge CLK); #1;
        check("busy_dren", 32'(dREN), 32'd1);
        RST = 1'b1; valid_in = 1'b0; memread_in = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        check("mid_rst_dren", 32'(dREN), 32'd0);
        check("mid_rst_stall", 32'(mem_stall), 32'd0);
        check("mid_rst_load", dMemLoad, 32'd0);
        check("mid_rst_scr", 32'(sc_result), 32'd0);
        do_op(0, 1, 0, 1, 32'h80, 32'h1, 1, 32'h0, 0, 32'h0);
        check("mid_rst_link_dwen", 32'(r_wen), 32'd0);
        check("mid_rst_link_stall", 32'(r_stall), 32'd1);

        check("never_both", 32'(r_both), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
